// File: rtl/problem_3_if.sv
// problem_3_if: groups the function-unit inputs (A/B/C, table write, coverage
// clear) and its registered results (E, tt_q, cov, cov_full) into one bundle.
//   master modport: drives A, B, C, tt_we, tt_wdata, clr_cov; observes results.
//   slave modport : consumes the inputs and drives E, tt_q, cov, cov_full.
interface problem_3_if;
  logic       A;
  logic       B;
  logic       C;
  logic       tt_we;
  logic [7:0] tt_wdata;
  logic       clr_cov;
  logic       E;
  logic [7:0] tt_q;
  logic [7:0] cov;
  logic       cov_full;

  modport master (
    output A, B, C, tt_we, tt_wdata, clr_cov,
    input  E, tt_q, cov, cov_full
  );

  modport slave (
    input  A, B, C, tt_we, tt_wdata, clr_cov,
    output E, tt_q, cov, cov_full
  );
endinterface

// File: rtl/problem_3.sv
// problem_3: registered three-input Boolean function unit.
// Every rising edge the 8-entry truth table is indexed by {A,B,C} and the
// selected bit is registered on E. The table resets to TT_RESET (majority)
// and can be rewritten at run time through tt_we/tt_wdata.
// Optional feature macro: PROBLEM_3_COVERAGE_EN adds a bitmap (cov) of the
// input combinations applied since reset or the last clr_cov, plus cov_full.
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : synchronous active-low reset
//   bus   : problem_3_if.slave (A, B, C, tt_we, tt_wdata, clr_cov in;
//           E, tt_q, cov, cov_full out; all outputs registered)
module problem_3 #(
  parameter logic [7:0] TT_RESET = 8'hE8
) (
  input  logic        clk,
  input  logic        rst_n,
  problem_3_if.slave  bus
);

  logic [2:0] idx_s;
  logic       e_d;
  logic       e_q;
  logic [7:0] table_d;
  logic [7:0] table_q;

  assign idx_s = {bus.A, bus.B, bus.C};

  // Next-state for result and table; evaluation always uses the current table,
  // so a write only affects inputs sampled from the following edge on.
  always_comb begin
    e_d     = table_q[idx_s];
    table_d = table_q;
    if (bus.tt_we) begin
      table_d = bus.tt_wdata;
    end else begin
      table_d = table_q;
    end
  end

  // Result and truth-table registers; reset overrides any pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q     <= 1'b0;
      table_q <= TT_RESET;
    end else begin
      e_q     <= e_d;
      table_q <= table_d;
    end
  end

  assign bus.E    = e_q;
  assign bus.tt_q = table_q;

`ifdef PROBLEM_3_COVERAGE_EN
  logic [7:0] cov_d;
  logic [7:0] cov_q;
  logic       cov_full_d;
  logic       cov_full_q;

  // Coverage next-state; a clear wins and drops the index sampled this cycle.
  // cov_full looks at the next bitmap so both registers move on the same edge.
  always_comb begin
    cov_d = cov_q;
    if (bus.clr_cov) begin
      cov_d = 8'h00;
    end else begin
      cov_d = cov_q | (8'h01 << idx_s);
    end
    cov_full_d = (cov_d == 8'hFF);
  end

  // Coverage bitmap and full-flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cov_q      <= 8'h00;
      cov_full_q <= 1'b0;
    end else begin
      cov_q      <= cov_d;
      cov_full_q <= cov_full_d;
    end
  end

  assign bus.cov      = cov_q;
  assign bus.cov_full = cov_full_q;
`else
  // Coverage not built: outputs held at zero, clr_cov has no effect.
  assign bus.cov      = 8'h00;
  assign bus.cov_full = 1'b0;
`endif

endmodule

// File: tb/tb_problem_3.sv
// tb_problem_3: scoreboard bench for problem_3. A driver applies directed
// vectors on the falling edge and pushes the hand-computed post-edge result
// into a queue; a monitor pops one entry per rising edge (sampled 1 time unit
// later) and compares E, tt_q, cov and cov_full.
// Coverage expectations follow PROBLEM_3_COVERAGE_EN: without it, cov and
// cov_full are expected to stay zero.
module tb_problem_3;

  typedef struct {
    logic       rst_n;
    logic [2:0] idx;
    logic       we;
    logic [7:0] wd;
    logic       clr;
    logic       e;
    logic [7:0] tt;
    logic [7:0] cov;
    logic       full;
  } vec_t;

  typedef struct {
    int         num;
    logic       e;
    logic [7:0] tt;
    logic [7:0] cov;
    logic       full;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  exp_t exp_q[$];

  problem_3_if bif ();

  problem_3 #(.TT_RESET(8'hE8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [2:0] idx, input logic we,
                     input logic [7:0] wd, input logic clr, input logic e,
                     input logic [7:0] tt, input logic [7:0] cov, input logic full);
    vec_t v;
    v.rst_n = r; v.idx = idx; v.we = we; v.wd = wd; v.clr = clr;
    v.e = e; v.tt = tt; v.cov = cov; v.full = full;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int num, input logic [7:0] act,
                     input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, num, act, req);
    end
  endtask

  // Monitor: one expected entry per rising edge once the driver has started.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("E", x.num, {7'd0, bif.E}, {7'd0, x.e});
      chk("tt_q", x.num, bif.tt_q, x.tt);
      chk("cov", x.num, bif.cov, x.cov);
      chk("cov_full", x.num, {7'd0, bif.cov_full}, {7'd0, x.full});
    end
  end

  initial begin
    exp_t x;
    int   waited;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bif.A = 1'b0; bif.B = 1'b0; bif.C = 1'b0;
    bif.tt_we = 1'b0; bif.tt_wdata = 8'h00; bif.clr_cov = 1'b0;

    //   rst   idx   we    wdata  clr   E     tt_q   cov    full
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE8, 8'h00, 1'b0);
    add(1'b0, 3'd7, 1'b1, 8'h55, 1'b1, 1'b0, 8'hE8, 8'h00, 1'b0); // reset beats write
    add(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE8, 8'h01, 1'b0); // majority sweep
    add(1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE8, 8'h03, 1'b0);
    add(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE8, 8'h07, 1'b0);
    add(1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE8, 8'h0F, 1'b0);
    add(1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE8, 8'h1F, 1'b0);
    add(1'b1, 3'd5, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE8, 8'h3F, 1'b0);
    add(1'b1, 3'd6, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE8, 8'h7F, 1'b0);
    add(1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE8, 8'hFF, 1'b1); // full on last bit
    add(1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1, 8'hE8, 8'h00, 1'b0); // clear drops idx 3
    add(1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE8, 8'h08, 1'b0);
    add(1'b1, 3'd7, 1'b1, 8'h96, 1'b0, 1'b1, 8'h96, 8'h88, 1'b0); // XOR3, old table
    add(1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 8'h96, 8'h88, 1'b0);
    add(1'b1, 3'd6, 1'b0, 8'h00, 1'b0, 1'b0, 8'h96, 8'hC8, 1'b0);
    add(1'b1, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 8'hC9, 1'b0);
    add(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'hC9, 1'b0);
    add(1'b1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'hCB, 1'b0); // back-to-back writes
    add(1'b1, 3'd1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'hCB, 1'b0);
    add(1'b1, 3'd2, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'hCF, 1'b0);
    add(1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE8, 8'h00, 1'b0); // mid-stream reset
    add(1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE8, 8'h80, 1'b0);
    add(1'b1, 3'd5, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'hA0, 1'b0);
    add(1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hB0, 1'b0);
    add(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hB1, 1'b0);
    add(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hB5, 1'b0);
    add(1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hB7, 1'b0);
    add(1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hBF, 1'b0);
    add(1'b1, 3'd6, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    add(1'b1, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0); // clear clears full
    add(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n        = vecs[i].rst_n;
      bif.A        = vecs[i].idx[2];
      bif.B        = vecs[i].idx[1];
      bif.C        = vecs[i].idx[0];
      bif.tt_we    = vecs[i].we;
      bif.tt_wdata = vecs[i].wd;
      bif.clr_cov  = vecs[i].clr;
      x.num = i;
      x.e   = vecs[i].e;
      x.tt  = vecs[i].tt;
`ifdef PROBLEM_3_COVERAGE_EN
      x.cov  = vecs[i].cov;
      x.full = vecs[i].full;
`else
      x.cov  = 8'h00;
      x.full = 1'b0;
`endif
      exp_q.push_back(x);
    end

    @(negedge clk);
    bif.tt_we   = 1'b0;
    bif.clr_cov = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
